// File: rtl/spi_master.sv
// spi_master: SPI master controlled through a small register bus.
// The host writes a word to SPI_TX. The block frames it with ss, shifts it out
// LSB first on mosi, and captures the same number of bits from miso. It then
// raises ready and, if enabled, pulses interrupt for one clk.
// Optional feature macro: SPI_MASTER_CLKDIV_REG_EN. When it is defined, a
// run-time SPI_CLKDIV register replaces the CLK_DIV parameter as the sclk
// half-period.

`ifndef SPI_DATA_W
`define SPI_DATA_W 32
`endif
`ifndef SPI_ADDR_W
`define SPI_ADDR_W 3
`endif
`ifndef SPI_TX
`define SPI_TX 0
`endif
`ifndef SPI_RX
`define SPI_RX 1
`endif
`ifndef SPI_READY
`define SPI_READY 2
`endif
`ifndef SPI_INTRRPT_EN
`define SPI_INTRRPT_EN 3
`endif
`ifndef SPI_CLKDIV
`define SPI_CLKDIV 4
`endif

module spi_master #(
  parameter int DATA_W  = `SPI_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   sclk,
  output logic                   ss,
  output logic                   mosi,
  input  logic                   miso,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  input  logic [`SPI_ADDR_W-1:0] address,
  input  logic                   we,
  input  logic                   sel,
  output logic                   interrupt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRELOAD = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [`SPI_ADDR_W-1:0] A_TX     = `SPI_ADDR_W'(`SPI_TX);
  localparam logic [`SPI_ADDR_W-1:0] A_RX     = `SPI_ADDR_W'(`SPI_RX);
  localparam logic [`SPI_ADDR_W-1:0] A_READY  = `SPI_ADDR_W'(`SPI_READY);
  localparam logic [`SPI_ADDR_W-1:0] A_IE     = `SPI_ADDR_W'(`SPI_INTRRPT_EN);

`ifdef SPI_MASTER_CLKDIV_REG_EN
  localparam logic [`SPI_ADDR_W-1:0] A_CLKDIV = `SPI_ADDR_W'(`SPI_CLKDIV);
  localparam int DIV_W = 16;
  logic [15:0]      r_clkdiv;
  logic [DIV_W-1:0] w_h_m1;
  // The stored divider is never 0, so H-1 cannot underflow.
  assign w_h_m1 = r_clkdiv - 16'd1;
`else
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [DIV_W-1:0] w_h_m1;
  assign w_h_m1 = DIV_W'(CLK_DIV - 1);
`endif

  logic [2:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic              r_phase;     // 0 = sclk high half, 1 = sclk low half
  logic [CNT_W-1:0]  r_bit;
  logic              r_start;     // accepted TX write waiting to enter PRELOAD
  logic              r_busy;
  logic              r_ready;
  logic              r_ie;
  logic              r_irq;
  logic              r_sclk;
  logic              r_ss;
  logic              r_mosi;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx;

  logic              w_div_end;
  logic              w_tx_acc;
  logic              w_rx_rd;
  logic              w_sample;
  logic              w_fall;
  logic              w_done;
  logic [DATA_W-1:0] w_tx_next;

  assign w_div_end = (r_div == w_h_m1);
  // A transfer is pending from the accepting edge onwards, which closes the
  // window before busy becomes visible.
  assign w_tx_acc  = sel & we & (address == A_TX) & ~r_busy & ~r_start;
  assign w_rx_rd   = sel & ~we & (address == A_RX);
  // Rising sclk edges: the end of SETUP, and the end of every low half in SHIFT
  // except the last one.
  assign w_sample  = w_div_end & ((r_state == S_SETUP) |
                     ((r_state == S_SHIFT) & r_phase & (r_bit != LAST_BIT)));
  assign w_fall    = w_div_end & (r_state == S_SHIFT) & ~r_phase;
  assign w_done    = w_div_end & (r_state == S_HOLD);
  assign w_tx_next = r_tx >> 1;

  assign sclk      = r_sclk;
  assign ss        = r_ss;
  assign mosi      = r_mosi;
  assign interrupt = r_irq;

  // Transfer sequencer, bus control flags and registered SPI pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
      r_sclk  <= 1'b0;
      r_ss    <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_rx_rd) r_ready <= 1'b0;
      if (sel & we & (address == A_IE)) r_ie <= data_in[0];
      if (w_tx_acc) begin
        r_start <= 1'b1;
        r_ready <= 1'b0;
      end
      if (r_state != S_IDLE) r_div <= w_div_end ? '0 : r_div + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (r_start) begin
            r_start <= 1'b0;
            r_state <= S_PRELOAD;
            r_busy  <= 1'b1;
            r_sclk  <= 1'b1;
            r_phase <= 1'b0;
            r_mosi  <= r_tx[0];
          end
        end
        S_PRELOAD: begin
          if (w_div_end) begin
            if (!r_phase) begin
              r_sclk  <= 1'b0;
              r_phase <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_ss    <= 1'b0;
              r_phase <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_state <= S_SHIFT;
            r_sclk  <= 1'b1;
            r_phase <= 1'b0;
            r_bit   <= '0;
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            if (!r_phase) begin
              r_sclk  <= 1'b0;
              r_phase <= 1'b1;
              r_mosi  <= w_tx_next[0];
            end else if (r_bit == LAST_BIT) begin
              r_state <= S_HOLD;
              r_phase <= 1'b0;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_sclk  <= 1'b1;
              r_phase <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          // The ready set here is written after the RX-read clear above, so it wins.
          if (w_div_end) begin
            r_state <= S_IDLE;
            r_ss    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_irq   <= r_ie;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data shift registers. They carry no reset, so a reset leaves the last rx word readable.
  always_ff @(posedge clk) begin
    if (w_tx_acc)      r_tx <= data_in;
    else if (w_fall)   r_tx <= w_tx_next;
    if (w_sample)      r_rx_sh <= {miso, r_rx_sh[DATA_W-1:1]};
    if (w_done)        r_rx <= r_rx_sh;
  end

`ifdef SPI_MASTER_CLKDIV_REG_EN
  // Run-time half-period. It is frozen while a transfer is pending or running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clkdiv <= 16'(CLK_DIV);
    end else if (sel & we & (address == A_CLKDIV) & ~r_busy & ~r_start) begin
      r_clkdiv <= (data_in[15:0] == 16'd0) ? 16'd1 : data_in[15:0];
    end
  end
`endif

  // Register read mux. Unmapped addresses read as zero.
  always_comb begin
    data_out = '0;
    case (address)
      A_RX:     data_out = r_rx;
      A_READY:  data_out[1:0] = {r_busy, r_ready};
`ifdef SPI_MASTER_CLKDIV_REG_EN
      A_CLKDIV: data_out = DATA_W'(r_clkdiv);
`endif
      default:  data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master (DATA_W=32, H=2) with a
// protocol-level SPI slave model and a scoreboard of the expected words.
// Build with SPI_MASTER_CLKDIV_REG_EN defined to also exercise SPI_CLKDIV.

module tb_spi_master;

  localparam logic [2:0] A_TX     = 3'd0;
  localparam logic [2:0] A_RX     = 3'd1;
  localparam logic [2:0] A_READY  = 3'd2;
  localparam logic [2:0] A_IE     = 3'd3;
  localparam logic [2:0] A_CLKDIV = 3'd4;
  localparam int         H        = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk, ss, mosi;
  logic        miso = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [2:0]  address = A_READY;
  logic        we = 1'b0;
  logic        sel = 1'b0;
  logic        interrupt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] q_mosi[$];   // words the slave must receive
  logic [31:0] q_miso[$];   // words RX must return

  // Slave model: it loads its word on a falling sclk edge while ss is high,
  // shifts on falling edges while selected, and samples mosi on rising edges.
  logic [31:0] s_tx_word = '0;
  logic [31:0] s_sh_tx   = '0;
  logic [31:0] s_rx      = '0;

  spi_master #(.DATA_W(32), .CLK_DIV(H)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .data_in(data_in), .data_out(data_out), .address(address),
    .we(we), .sel(sel), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  always @(negedge sclk) begin
    if (ss) begin
      s_sh_tx = s_tx_word;
      miso    = s_tx_word[0];
    end else begin
      s_sh_tx = s_sh_tx >> 1;
      miso    = s_sh_tx[0];
    end
  end

  always @(posedge sclk) begin
    if (!ss) s_rx = {mosi, s_rx[31:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The bus write is sampled on the returned edge (edge 0). The task returns 1 time unit after it.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; data_in = d; sel = 1'b1; we = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; address = A_READY;
  endtask

  // RX read: compares the word, then checks that the read cleared ready.
  task automatic rx_read(input string tag, input logic [31:0] exp);
    @(negedge clk);
    address = A_RX; sel = 1'b1; we = 1'b0;
    #1 chk({tag, "_rx"}, data_out, exp);
    @(posedge clk); #1;
    sel = 1'b0; address = A_READY;
    #1 chk({tag, "_ready_clr"}, data_out, 32'h0);
  endtask

  // One full transfer with cycle-accurate timing checks. The expected
  // timing is derived from the half-period h.
  task automatic xfer(input string tag, input logic [31:0] tx, input logic [31:0] stx,
                      input int h, input bit exp_irq, input bit inject, input bit rd_at_end);
    int e_fall = -1, e_rise = -1, e_ready = -1, e_irq = -1, n_irq = 0;
    int n_r = 0, r2 = -1, r3 = -1;
    logic prev = 1'b0;
    int exp_done = 1 + h * (2 * 32 + 4);
    s_tx_word = stx;
    q_mosi.push_back(tx);
    q_miso.push_back(stx);
    bus_write(A_TX, tx);
    for (int e = 1; e <= exp_done + 20 && e_ready < 0; e++) begin
      @(posedge clk); #1;
      if (inject && e == 20) begin address = A_TX; data_in = 32'hFFFF_FFFF; sel = 1'b1; we = 1'b1; end
      if (inject && e == 21) begin sel = 1'b0; we = 1'b0; address = A_READY; end
      if (rd_at_end && e == exp_done - 1) begin address = A_RX; sel = 1'b1; we = 1'b0; end
      if (rd_at_end && e == exp_done) begin sel = 1'b0; address = A_READY; end
      #1;
      if (e == 10) chk({tag, "_busy"}, data_out, 32'h2);
      if (!ss && e_fall < 0) e_fall = e;
      if (e_fall >= 0 && ss && e_rise < 0) e_rise = e;
      if (sclk && !prev) begin
        n_r++;
        if (n_r == 2) r2 = e;
        if (n_r == 3) r3 = e;
      end
      prev = sclk;
      if (interrupt) begin n_irq++; e_irq = e; end
      if (address == A_READY && data_out[0] && e_ready < 0) e_ready = e;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      if (interrupt) n_irq++;
    end
    chk({tag, "_ss_fall_edge"}, e_fall, 1 + 2 * h);
    chk({tag, "_ss_low_len"}, e_rise - e_fall, exp_done - (1 + 2 * h));
    chk({tag, "_ready_edge"}, e_ready, exp_done);
    chk({tag, "_sclk_period"}, r3 - r2, 2 * h);
    chk({tag, "_irq_count"}, n_irq, exp_irq ? 1 : 0);
    if (exp_irq) chk({tag, "_irq_edge"}, e_irq, e_ready);
    chk({tag, "_ready_held"}, data_out, 32'h1);
    chk({tag, "_slave_rx"}, s_rx, q_mosi.pop_front());
    rx_read(tag, q_miso.pop_front());
    $display("xfer %s: tx=0x%08h slave_tx=0x%08h H=%0d done_edge=%0d irqs=%0d",
             tag, tx, stx, h, e_ready, n_irq);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_ss", ss, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_irq", interrupt, 1'b0);
    chk("rst_ready", data_out, 32'h0);
    @(negedge clk) rst = 1'b1;

    // Unmapped reads return zero.
    @(negedge clk) address = 3'd7;
    #1 chk("unmapped_rd", data_out, 32'h0);
`ifndef SPI_MASTER_CLKDIV_REG_EN
    address = A_CLKDIV;
    #1 chk("clkdiv_unmapped", data_out, 32'h0);
`endif
    address = A_READY;

    // Basic transfer, no interrupt.
    xfer("basic", 32'hA5A5_1234, 32'hDEAD_BEEF, H, 1'b0, 1'b0, 1'b0);

    // Interrupt enabled: exactly one pulse, coincident with ready.
    bus_write(A_IE, 32'h1);
    xfer("irq_on", 32'h0000_0001, 32'h8000_0001, H, 1'b1, 1'b0, 1'b0);
    bus_write(A_IE, 32'h0);

    // TX write while busy is dropped.
    xfer("tx_busy", 32'h0F0F_3C3C, 32'h1357_9BDF, H, 1'b0, 1'b1, 1'b0);

    // RX read in the completion cycle loses to the ready set.
    xfer("rd_collide", 32'h55AA_00FF, 32'hCAFE_F00D, H, 1'b0, 1'b0, 1'b1);

    // Reset during the 10th bit (SHIFT starts at edge 7; bit 9 is high 43..44).
    bus_write(A_IE, 32'h1);
    s_tx_word = 32'h2468_ACE0;
    bus_write(A_TX, 32'h1234_5678);
    repeat (44) @(posedge clk);
    #2;
    chk("mid_sclk_before", sclk, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ss", ss, 1'b1);
    chk("mid_rst_sclk", sclk, 1'b0);
    chk("mid_rst_mosi", mosi, 1'b0);
    chk("mid_rst_ready", data_out, 32'h0);
    @(negedge clk) rst = 1'b1;
    $display("reset during bit 10 applied");

    // Interrupt enable was cleared by the reset, so no pulse is expected here.
    xfer("after_rst", 32'hC001_D00D, 32'h0BAD_F00D, H, 1'b0, 1'b0, 1'b0);

`ifdef SPI_MASTER_CLKDIV_REG_EN
    @(negedge clk) address = A_CLKDIV;
    #1 chk("clkdiv_reset", data_out, H);
    bus_write(A_CLKDIV, 32'd5);
    address = A_CLKDIV;
    #1 chk("clkdiv_5", data_out, 32'd5);
    address = A_READY;
    xfer("div5", 32'h7777_1111, 32'h9999_2222, 5, 1'b0, 1'b0, 1'b0);
    bus_write(A_CLKDIV, 32'd0);
    address = A_CLKDIV;
    #1 chk("clkdiv_0_as_1", data_out, 32'd1);
    address = A_READY;
    xfer("div1", 32'h3141_5926, 32'h2718_2818, 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
